// File: rtl/sd_stream_driver.sv
// sd_stream_driver: sends the R-matrix as three channel beats, then streams buffered vectors to the sphere decoder.
// Optional watchdog (timeout_err plus channel resend) is enabled by defining SD_DRV_TIMEOUT_EN.
module sd_stream_driver #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 cfg_we,
  input  logic [3:0]           cfg_addr,
  input  logic [2*WIDTH-1:0]   cfg_wdata,
  input  logic                 ch_start,
  output logic                 ch_busy,
  input  logic                 vec_valid,
  output logic                 vec_ready,
  input  logic [8*WIDTH-1:0]   vec_data,
  output logic [8*WIDTH-1:0]   InData,
  output logic                 flagChannelorData,
  input  logic [11:0]          dec_out_data,
  input  logic                 dec_output_ready,
  output logic                 res_valid,
  output logic [11:0]          res_data,
  output logic                 timeout_err
);
  localparam int unsigned VW = 8 * WIDTH;
  localparam int unsigned CW = 2 * WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned NW = AW + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CH0  = 3'd1;
  localparam logic [2:0] S_CH1  = 3'd2;
  localparam logic [2:0] S_CH2  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_RUN  = 3'd5;

  logic [2:0]    state, state_nxt;
  logic [VW-1:0] indata_nxt;
  logic          flag_nxt;
  logic          staged_valid, staged_nxt;
  logic          inflight, inflight_nxt;
  logic          pending, pending_nxt;
  logic          res_valid_nxt;
  logic [11:0]   res_data_nxt;
  logic          to_hit;

  logic [CW-1:0] coef [10];
  logic [VW-1:0] beat0, beat1, beat2;

  logic [VW-1:0] fifo_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [NW-1:0] count, count_nxt;
  logic          push, pop, fifo_empty;
  logic [VW-1:0] fifo_head;

  // Real part sits in the low half of each coefficient, so entries pack directly as (re, im) slice pairs.
  assign beat0 = {coef[3], coef[2], coef[1], coef[0]};
  assign beat1 = {coef[7], coef[6], coef[5], coef[4]};
  assign beat2 = {{(2*CW){1'b0}}, coef[9], coef[8]};

  assign push       = vec_valid && vec_ready;
  assign fifo_empty = (count == '0);
  assign fifo_head  = fifo_mem[rd_ptr];
  assign count_nxt  = count + NW'(push) - NW'(pop);

`ifdef SD_DRV_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;
  logic          to_run;

  // Watchdog counts RUN cycles with a vector inside the decoder and no OutputReady.
  assign to_run = (state == S_RUN) && inflight && !dec_output_ready && !ch_start;
  assign to_hit = to_run && (to_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      to_cnt <= (to_run && !to_hit) ? to_cnt + TW'(1) : '0;
      if (to_hit) timeout_err <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign to_hit         = 1'b0;
  assign timeout_err    = 1'b0;
`endif

  // Next-state and registered-output values; outputs hold the value belonging to the next state.
  always_comb begin
    state_nxt     = state;
    indata_nxt    = InData;
    flag_nxt      = flagChannelorData;
    staged_nxt    = staged_valid;
    inflight_nxt  = inflight;
    pending_nxt   = 1'b0;
    res_valid_nxt = pending;
    res_data_nxt  = pending ? dec_out_data : res_data;
    pop           = 1'b0;
    case (state)
      S_IDLE: begin
        indata_nxt = '0;
        flag_nxt   = 1'b0;
        if (ch_start) begin
          state_nxt  = S_CH0;
          indata_nxt = beat0;
          flag_nxt   = 1'b1;
        end
      end
      S_CH0: begin
        state_nxt  = S_CH1;
        indata_nxt = beat1;
        flag_nxt   = 1'b1;
      end
      S_CH1: begin
        state_nxt  = S_CH2;
        indata_nxt = beat2;
        flag_nxt   = 1'b1;
      end
      S_CH2: begin
        state_nxt  = S_HOLD;
        indata_nxt = '0;
        flag_nxt   = 1'b1;
      end
      S_HOLD: begin
        indata_nxt = '0;
        flag_nxt   = 1'b1;
        if (!fifo_empty) begin
          pop          = 1'b1;
          state_nxt    = S_RUN;
          indata_nxt   = fifo_head;
          flag_nxt     = 1'b0;
          inflight_nxt = 1'b1;
          staged_nxt   = 1'b0;
        end
      end
      S_RUN: begin
        flag_nxt = 1'b0;
        if (ch_start || to_hit) begin
          // Reload drops the in-flight result, any pending capture and the staged vector.
          state_nxt     = S_CH0;
          indata_nxt    = beat0;
          flag_nxt      = 1'b1;
          staged_nxt    = 1'b0;
          inflight_nxt  = 1'b0;
          res_valid_nxt = 1'b0;
          res_data_nxt  = res_data;
        end else if (dec_output_ready) begin
          inflight_nxt = staged_valid;
          pending_nxt  = inflight;
          if (!fifo_empty) begin
            pop        = 1'b1;
            indata_nxt = fifo_head;
            staged_nxt = 1'b1;
          end else begin
            indata_nxt = '0;
            staged_nxt = 1'b0;
          end
        end else if (!staged_valid) begin
          if (!fifo_empty) begin
            pop        = 1'b1;
            indata_nxt = fifo_head;
            staged_nxt = 1'b1;
          end else begin
            indata_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt  = S_IDLE;
        indata_nxt = '0;
        flag_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state             <= S_IDLE;
      InData            <= '0;
      flagChannelorData <= 1'b0;
      staged_valid      <= 1'b0;
      inflight          <= 1'b0;
      pending           <= 1'b0;
      res_valid         <= 1'b0;
      res_data          <= '0;
      ch_busy           <= 1'b0;
      vec_ready         <= 1'b0;
      rd_ptr            <= '0;
      wr_ptr            <= '0;
      count             <= '0;
    end else begin
      state             <= state_nxt;
      InData            <= indata_nxt;
      flagChannelorData <= flag_nxt;
      staged_valid      <= staged_nxt;
      inflight          <= inflight_nxt;
      pending           <= pending_nxt;
      res_valid         <= res_valid_nxt;
      res_data          <= res_data_nxt;
      ch_busy           <= (state_nxt == S_CH0) || (state_nxt == S_CH1) ||
                           (state_nxt == S_CH2) || (state_nxt == S_HOLD);
      vec_ready         <= (count_nxt != NW'(DEPTH));
      count             <= count_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
    end
  end

  // Coefficient file is frozen while the channel is being sent.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < 10; i++) coef[i] <= '0;
    end else if (cfg_we && !ch_busy && (cfg_addr <= 4'd9)) begin
      coef[cfg_addr] <= cfg_wdata;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifo_mem[wr_ptr] <= vec_data;
  end

endmodule

// File: tb/tb_sd_stream_driver.sv
// Bench for sd_stream_driver: directed sequence with random vectors and results,
// checked against a transaction-level decoder/scoreboard model.
`timescale 1ns/1ps
module tb_sd_stream_driver;
  localparam int unsigned W  = 32;
  localparam int unsigned D  = 4;
  localparam int unsigned VW = 8 * W;

  logic          Clk = 1'b0;
  logic          Reset, cfg_we, ch_start, vec_valid, dec_output_ready;
  logic [3:0]    cfg_addr;
  logic [2*W-1:0] cfg_wdata;
  logic [VW-1:0] vec_data, InData;
  logic [11:0]   dec_out_data, res_data;
  logic          ch_busy, vec_ready, flagChannelorData, res_valid, timeout_err;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [W-1:0]  m_re [10];
  logic [W-1:0]  m_im [10];
  logic [VW-1:0] exp_q [$];
  logic          cur_real;

  always #5 Clk = ~Clk;

  sd_stream_driver #(.WIDTH(W), .DEPTH(D)) dut (
    .Clk(Clk), .Reset(Reset),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata),
    .ch_start(ch_start), .ch_busy(ch_busy),
    .vec_valid(vec_valid), .vec_ready(vec_ready), .vec_data(vec_data),
    .InData(InData), .flagChannelorData(flagChannelorData),
    .dec_out_data(dec_out_data), .dec_output_ready(dec_output_ready),
    .res_valid(res_valid), .res_data(res_data), .timeout_err(timeout_err)
  );

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Channel beat b: slice s carries the real (even s) or imaginary (odd s) part of R[4b + s/2].
  function automatic logic [VW-1:0] beat(input int b);
    logic [VW-1:0] v;
    int k;
    v = '0;
    for (int s = 0; s < 8; s++) begin
      k = 4 * b + s / 2;
      if (k < 10) v[s*W +: W] = (s % 2 == 0) ? m_re[k] : m_im[k];
    end
    return v;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*W +: W] = $urandom();
    v[0] = 1'b1;  // never all-zero, so real vectors differ from filler
    return v;
  endfunction

  task automatic push(input logic [VW-1:0] v);
    chk("vec_ready_on_push", vec_ready, 1);
    vec_valid = 1'b1;
    vec_data  = v;
    tick();
    vec_valid = 1'b0;
    exp_q.push_back(v);
  endtask

  // Decoder model: at OutputReady it returns d for the vector it held and takes the next one from InData.
  task automatic ready_pulse(input logic [11:0] d);
    logic [VW-1:0] exp_in;
    logic had;
    had    = cur_real;
    exp_in = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    chk("indata_at_ready", InData, exp_in);
    dec_output_ready = 1'b1;
    dec_out_data     = d;
    tick();
    dec_output_ready = 1'b0;
    chk("res_valid_r1", res_valid, 0);
    tick();
    chk("res_valid_r2", res_valid, had);
    if (had) chk("res_data", res_data, d);
    dec_out_data = 12'($urandom());
    tick();
    chk("res_valid_r3", res_valid, 0);
    cur_real = (exp_in != '0);
  endtask

  // Entered just after the edge that accepted ch_start; ends in HOLD.
  task automatic check_channel(input bit poke);
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("ch%0d_flag", b), flagChannelorData, 1);
      chk($sformatf("ch%0d_busy", b), ch_busy, 1);
      chk($sformatf("ch%0d_beat", b), InData, beat(b));
      chk($sformatf("ch%0d_no_res", b), res_valid, 0);
      if (poke && b == 0) begin
        cfg_we    = 1'b1;
        cfg_addr  = 4'd0;
        cfg_wdata = {2{32'hDEAD_BEEF}};
      end
      tick();
      cfg_we = 1'b0;
    end
    chk("hold_flag", flagChannelorData, 1);
    chk("hold_indata", InData, 0);
    chk("hold_busy", ch_busy, 1);
  endtask

  initial begin
    logic [VW-1:0] v;
    int acc;
    Reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; ch_start = 1'b0;
    vec_valid = 1'b0; vec_data = '0; dec_output_ready = 1'b0; dec_out_data = '0;
    cur_real = 1'b0;
    for (int k = 0; k < 10; k++) begin m_re[k] = '0; m_im[k] = '0; end
    tick(); tick();
    chk("rst_indata", InData, 0);
    chk("rst_flag", flagChannelorData, 0);
    chk("rst_busy", ch_busy, 0);
    chk("rst_vec_ready", vec_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_timeout", timeout_err, 0);
    Reset = 1'b0;
    tick();
    chk("vec_ready_idle", vec_ready, 1);

    // Coefficients R[k] = (k, -k)
    for (int k = 0; k < 10; k++) begin
      cfg_we = 1'b1; cfg_addr = 4'(k); cfg_wdata = {32'(-k), 32'(k)};
      m_re[k] = 32'(k); m_im[k] = 32'(-k);
      tick();
    end
    cfg_we = 1'b1; cfg_addr = 4'd12; cfg_wdata = {2{32'h1234_5678}};
    tick();
    cfg_we = 1'b0;
    chk("idle_flag", flagChannelorData, 0);
    chk("idle_indata", InData, 0);

    ch_start = 1'b1; tick(); ch_start = 1'b0;
    check_channel(1'b1);
    ch_start = 1'b1; tick(); ch_start = 1'b0;
    chk("hold_ignores_start_flag", flagChannelorData, 1);
    chk("hold_ignores_start_indata", InData, 0);

    // First vector captured from HOLD
    push(rand_vec());
    chk("hold_wait_flag", flagChannelorData, 1);
    tick();
    v = exp_q.pop_front();
    chk("first_vec_indata", InData, v);
    chk("first_vec_flag", flagChannelorData, 0);
    cur_real = 1'b1;
    tick();
    chk("run_indata_empty", InData, 0);
    chk("run_flag", flagChannelorData, 0);
    chk("run_busy", ch_busy, 0);

    // Streaming, then starvation
    push(rand_vec());
    push(rand_vec());
    tick(); tick();
    ready_pulse(12'hA5C);
    ready_pulse(12'h3F1);
    ready_pulse(12'($urandom()));
    ready_pulse(12'($urandom()));
    ready_pulse(12'($urandom()));

    // Backpressure: one vector goes to the staging slot, DEPTH more fill the FIFO
    acc = 0;
    for (int i = 0; i < int'(D) + 4; i++) begin
      v = rand_vec();
      vec_valid = 1'b1;
      vec_data  = v;
      if (vec_ready) begin exp_q.push_back(v); acc++; end
      tick();
    end
    vec_valid = 1'b0;
    chk("accepted_count", VW'(acc), VW'(D + 1));
    chk("vec_ready_full", vec_ready, 0);
    ready_pulse(12'($urandom()));
    chk("vec_ready_after_pop", vec_ready, 1);
    for (int i = 0; i < int'(D) + 1; i++) ready_pulse(12'($urandom()));

    // Reload while a result is pending
    push(rand_vec());
    tick(); tick();
    ready_pulse(12'($urandom()));
    dec_output_ready = 1'b1; dec_out_data = 12'h777;
    tick();
    dec_output_ready = 1'b0;
    ch_start = 1'b1; tick(); ch_start = 1'b0;
    check_channel(1'b0);
    push(rand_vec());
    tick();
    v = exp_q.pop_front();
    chk("reload_first_vec", InData, v);
    chk("reload_first_flag", flagChannelorData, 0);
    tick();
    chk("reload_run_indata", InData, 0);

    // Reset mid-operation clears FIFO and coefficient file
    push(rand_vec());
    tick();
    Reset = 1'b1;
    tick();
    chk("mid_rst_indata", InData, 0);
    chk("mid_rst_flag", flagChannelorData, 0);
    chk("mid_rst_busy", ch_busy, 0);
    chk("mid_rst_vec_ready", vec_ready, 0);
    chk("mid_rst_res_valid", res_valid, 0);
    chk("mid_rst_res_data", res_data, 0);
    Reset = 1'b0;
    exp_q.delete();
    for (int k = 0; k < 10; k++) begin m_re[k] = '0; m_im[k] = '0; end
    tick();
    chk("post_rst_vec_ready", vec_ready, 1);
    ch_start = 1'b1; tick(); ch_start = 1'b0;
    check_channel(1'b0);
    tick();
    chk("post_rst_hold_flag", flagChannelorData, 1);
    chk("post_rst_hold_indata", InData, 0);
    chk("timeout_err_off", timeout_err, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
